// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request and data-memory bus bundle for load_store_unit
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wr;
  logic [31:0] dm_rdata;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata, dm_rdata,
    output ready, done, err, rdata, dm_addr, dm_wdata, dm_wr
  );

  modport mem (
    input  dm_addr, dm_wdata, dm_wr,
    output dm_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end over a word-wide data memory
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

  state_t            state, state_n;
  logic              l_we;
  logic [2:0]        l_f3;
  logic [ADDR_W+1:0] l_addr;
  logic [15:0]       l_wdata;
  logic [31:0]       wbuf;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              req_err;
  logic              req_sw;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              unused_addr;

  assign accept      = bus.req && (state == IDLE);
  assign req_sw      = bus.we && (bus.funct3 == 3'b010);
  assign unused_addr = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    if (bus.we) begin
      case (bus.funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = bus.addr[0];
        3'b010:  req_err = (bus.addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (bus.funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = bus.addr[0];
        3'b010:         req_err = (bus.addr[1:0] != 2'b00);
        default:        req_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)     state_n = DONE;
          else if (req_sw) state_n = WR;
          else             state_n = RD;
        end
      end
      RD:      state_n = LAT;
      LAT:     state_n = l_we ? WR : DONE;
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Little-endian lane extraction and merge from the registered read word.
  always_comb begin
    byte_sel = 8'h00;
    case (l_addr[1:0])
      2'd0: byte_sel = bus.dm_rdata[7:0];
      2'd1: byte_sel = bus.dm_rdata[15:8];
      2'd2: byte_sel = bus.dm_rdata[23:16];
      2'd3: byte_sel = bus.dm_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = l_addr[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

    load_val = bus.dm_rdata;
    case (l_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h000000, byte_sel};
      3'b101:  load_val = {16'h0000, half_sel};
      default: load_val = bus.dm_rdata;
    endcase

    merged = bus.dm_rdata;
    if (l_f3[0]) begin
      if (l_addr[1]) merged[31:16] = l_wdata;
      else           merged[15:0]  = l_wdata;
    end else begin
      merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_we    <= 1'b0;
      l_f3    <= 3'b000;
      l_addr  <= '0;
      l_wdata <= 16'h0000;
      wbuf    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        l_we    <= bus.we;
        l_f3    <= bus.funct3;
        l_addr  <= bus.addr[ADDR_W+1:0];
        l_wdata <= bus.wdata[15:0];
        err_q   <= req_err;
        if (req_sw && !req_err) wbuf <= bus.wdata;
      end
      if (state == LAT) begin
        if (l_we) wbuf    <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = (state == DONE) && err_q;
  assign bus.rdata    = rdata_q;
  assign bus.dm_wr    = (state == WR);
  assign bus.dm_wdata = wbuf;
  assign bus.dm_addr  = {{(32-ADDR_W){1'b0}}, l_addr[ADDR_W+1:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a word memory model
module tb_load_store_unit;

  typedef struct {
    int          id;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if io();
  load_store_unit #(.ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(io));

  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (io.dm_wr) mem[io.dm_addr[4:0]] <= io.dm_wdata;
    else          io.dm_rdata <= mem[io.dm_addr[4:0]];
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_done = 0;
  int   gap = 0;
  int   wr_seen = 0;
  int   stray_wr = 0;
  int   spurious = 0;
  vec_t q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int id, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input int nwr, input logic [31:0] waddr, input logic [31:0] wword);
    vec_t v;
    v.id = id; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.nwr = nwr; v.waddr = waddr; v.wword = wword;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: the oldest outstanding expectation is retired on each done.
  always @(negedge clk) begin
    if (rst) begin
      wr_seen = 0;
    end else begin
      if (io.req && io.ready) begin
        acc_cyc = cyc;
        gap = cyc - last_done;
      end
      if (io.dm_wr) begin
        if (q.size() == 0) stray_wr++;
        else begin
          wr_seen++;
          check($sformatf("v%0d dm_addr", q[0].id), io.dm_addr, q[0].waddr);
          check($sformatf("v%0d dm_wdata", q[0].id), io.dm_wdata, q[0].wword);
        end
      end
      if (io.done) begin
        if (q.size() == 0) spurious++;
        else begin
          vec_t e;
          e = q.pop_front();
          check($sformatf("v%0d err", e.id), {31'b0, io.err}, {31'b0, e.err});
          check($sformatf("v%0d rdata", e.id), io.rdata, e.rdata);
          check($sformatf("v%0d latency", e.id), cyc - acc_cyc, e.lat);
          check($sformatf("v%0d write_pulses", e.id), wr_seen, e.nwr);
        end
        wr_seen = 0;
        last_done = cyc;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic issue(input vec_t v);
    int n = 0;
    @(posedge clk); #2;
    while (!io.ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    io.we = v.we; io.funct3 = v.f3; io.addr = v.addr; io.wdata = v.wdata;
    io.req = 1'b1;
    q.push_back(v);
    @(posedge clk); #2;
    io.req = 1'b0;
    io.we = 1'($urandom); io.funct3 = 3'($urandom);
    io.addr = $urandom; io.wdata = $urandom;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    io.req = 1'b0; io.we = 1'b0; io.funct3 = 3'b000; io.addr = 32'h0; io.wdata = 32'h0;
    #1 rst = 1'b1;
    #1;
    check("rst ready", {31'b0, io.ready}, 32'd1);
    check("rst done", {31'b0, io.done}, 32'd0);
    check("rst err", {31'b0, io.err}, 32'd0);
    check("rst rdata", io.rdata, 32'h0);
    check("rst dm_wr", {31'b0, io.dm_wr}, 32'd0);
    check("rst dm_addr", io.dm_addr, 32'h0);
    check("rst dm_wdata", io.dm_wdata, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    tbl.push_back(mk( 0, 1, 3'b010, 32'h8,  32'hDEADBEEF, 0, 32'h0,        2, 1, 32'd2, 32'hDEADBEEF));
    tbl.push_back(mk( 1, 0, 3'b000, 32'h9,  32'h0,        0, 32'hFFFFFFBE, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 2, 0, 3'b100, 32'h9,  32'h0,        0, 32'h000000BE, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 3, 0, 3'b001, 32'hA,  32'h0,        0, 32'hFFFFDEAD, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 4, 0, 3'b101, 32'hA,  32'h0,        0, 32'h0000DEAD, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 5, 0, 3'b010, 32'h8,  32'h0,        0, 32'hDEADBEEF, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 6, 1, 3'b000, 32'hB,  32'h00000012, 0, 32'hDEADBEEF, 4, 1, 32'd2, 32'h12ADBEEF));
    tbl.push_back(mk( 7, 0, 3'b010, 32'h8,  32'h0,        0, 32'h12ADBEEF, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk( 8, 1, 3'b001, 32'h8,  32'hAAAA5555, 0, 32'h12ADBEEF, 4, 1, 32'd2, 32'h12AD5555));
    tbl.push_back(mk( 9, 0, 3'b010, 32'h8,  32'h0,        0, 32'h12AD5555, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(10, 0, 3'b010, 32'h6,  32'h0,        1, 32'h12AD5555, 1, 0, 32'd0, 32'h0));
    tbl.push_back(mk(11, 1, 3'b001, 32'h3,  32'h00001234, 1, 32'h12AD5555, 1, 0, 32'd0, 32'h0));
    tbl.push_back(mk(12, 0, 3'b011, 32'h8,  32'h0,        1, 32'h12AD5555, 1, 0, 32'd0, 32'h0));
    tbl.push_back(mk(13, 0, 3'b111, 32'h8,  32'h0,        1, 32'h12AD5555, 1, 0, 32'd0, 32'h0));
    tbl.push_back(mk(14, 1, 3'b100, 32'h10, 32'h00000005, 1, 32'h12AD5555, 1, 0, 32'd0, 32'h0));
    tbl.push_back(mk(15, 1, 3'b010, 32'h84, 32'h11223344, 0, 32'h12AD5555, 2, 1, 32'd1, 32'h11223344));
    tbl.push_back(mk(16, 0, 3'b010, 32'h4,  32'h0,        0, 32'h11223344, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(17, 0, 3'b001, 32'h6,  32'h0,        0, 32'h00001122, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(18, 0, 3'b000, 32'h7,  32'h0,        0, 32'h00000011, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(19, 1, 3'b000, 32'h5,  32'hFFFFFF80, 0, 32'h00000011, 4, 1, 32'd1, 32'h11228044));
    tbl.push_back(mk(20, 0, 3'b000, 32'h5,  32'h0,        0, 32'hFFFFFF80, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(21, 0, 3'b101, 32'h8,  32'h0,        0, 32'h00005555, 3, 0, 32'd0, 32'h0));
    tbl.push_back(mk(22, 0, 3'b100, 32'h8,  32'h0,        0, 32'h00000055, 3, 0, 32'd0, 32'h0));

    foreach (tbl[i]) issue(tbl[i]);

    // Abort an SB in LAT: nothing may be written and no done may follow.
    @(posedge clk); #2;
    io.we = 1'b1; io.funct3 = 3'b000; io.addr = 32'h8; io.wdata = 32'h00000077; io.req = 1'b1;
    @(posedge clk); #2;
    io.req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort dm_wr", {31'b0, io.dm_wr}, 32'd0);
    check("abort ready", {31'b0, io.ready}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("abort ready_after", {31'b0, io.ready}, 32'd1);
    check("abort rdata_cleared", io.rdata, 32'h0);
    check("abort stray_writes", stray_wr, 0);
    check("abort spurious_done", spurious, 0);
    issue(mk(30, 0, 3'b010, 32'h8, 32'h0, 0, 32'h12AD5555, 3, 0, 32'd0, 32'h0));

    // req held high: inputs change after acceptance, second request follows DONE directly.
    begin
      int n = 0;
      @(posedge clk); #2;
      io.we = 1'b1; io.funct3 = 3'b010; io.addr = 32'hC; io.wdata = 32'hCAFEF00D; io.req = 1'b1;
      q.push_back(mk(31, 1, 3'b010, 32'hC, 32'hCAFEF00D, 0, 32'h12AD5555, 2, 1, 32'd3, 32'hCAFEF00D));
      q.push_back(mk(32, 0, 3'b010, 32'hC, 32'h0,        0, 32'hCAFEF00D, 3, 0, 32'd0, 32'h0));
      @(posedge clk); #2;
      io.we = 1'b0; io.wdata = 32'h0BADF00D;
      while (q.size() > 1 && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
      @(posedge clk); #2;
      io.req = 1'b0;
      check("held accept_gap", gap, 1);
      drain();
    end

    check("final stray_writes", stray_wr, 0);
    check("final spurious_done", spurious, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end for the RISC-V core's data memory. It takes one memory request at a time from the execute/memory stage and converts it into word-wide accesses to the data memory array. It handles RISC-V load/store widths, sign and zero extension, sub-word stores by read-modify-write, and misalignment/illegal-width detection. It sits directly upstream of the data memory: it drives that memory's address, write data and write enable, and consumes its registered read port.

## Interface
Parameters:
- ADDR_W, 5, word-index width; memory depth 2^ADDR_W words.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid; accepted on a rising edge when req && ready.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/half/word is used.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned or illegal funct3.
- rdata  out  32  extended load result; held until the next successful load completes.
- dm_addr  out  32  word index, zero-extended addr[ADDR_W+1:2].
- dm_wdata  out  32  word to write.
- dm_wr  out  1  memory write enable; 0 means read.
- dm_rdata  in  32  memory read port; it updates on the rising edge after a cycle with dm_wr=0.

## Operation
- On acceptance, latch we, funct3, addr and wdata. Input changes after acceptance are ignored.
- FSM states: IDLE, RD, LAT, WR, DONE.
- IDLE transitions on accept:
  - Error request → DONE.
  - SW → WR.
  - Any load, SB or SH → RD.
- RD: dm_wr=0 and dm_addr=latched index. The memory captures the word at the end of this cycle. Next state is LAT.
- LAT: dm_rdata is valid.
  - Load: rdata is registered with the extended value at the end of LAT; next state is DONE.
  - SB/SH: the merged word is registered into the write buffer; next state is WR.
- WR: dm_wr=1, dm_wdata = write buffer (for SW, the latched wdata). Next state is DONE.
- DONE: done=1, err valid. Next state is IDLE.
- Lane selection is little-endian:
  - A byte at addr[1:0]=k occupies bits [8k+7:8k].
  - A halfword at addr[1]=h occupies bits [16h+15:16h].
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Merge: replace only the addressed lanes of the read word with wdata[7:0] or wdata[15:0]; all other lanes are preserved.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠00.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ≥ 011.
- On error: no memory write occurs, rdata is unchanged, and err=1 during DONE.
- dm_wr is high only in WR, which gives exactly one write pulse per successful store.
- Address bits above ADDR_W+1 are ignored (wrap modulo memory depth).

## Timing
- Reset values, asynchronous:
  - state=IDLE; ready=1.
  - done=0, err=0, rdata=0.
  - dm_wr=0, dm_addr=0, dm_wdata=0; write buffer=0.
- Latency is the cycle count from the accepting edge to the done-high cycle, inclusive:
  - Error: 1.
  - SW: 2.
  - Loads: 3.
  - SB/SH: 4.
- ready returns high in the cycle after DONE. There is no acceptance during DONE, so the minimum request spacing is latency+1 cycles.
- Reset asserted mid-operation:
  - The FSM aborts immediately and dm_wr drops asynchronously.
  - A partially merged SB/SH word is never written.
  - No done pulse is issued for the aborted request.
- If req is held high continuously, a new request is accepted on the first edge in IDLE.

## Test plan
- Reset, then SW addr 0x8 wdata 0xDEADBEEF → dm_wr high exactly 1 cycle with dm_addr=2 and dm_wdata=0xDEADBEEF; done 2 cycles after accept; err=0.
- Loads after the SW above, each with done 3 cycles after accept:
  - LB 0x9 → rdata 0xFFFFFFBE.
  - LBU 0x9 → 0x000000BE.
  - LH 0xA → 0xFFFFDEAD.
  - LHU 0xA → 0x0000DEAD.
  - LW 0x8 → 0xDEADBEEF.
- Sub-word stores, each with one dm_wr pulse and done 4 cycles after accept:
  - SB 0xB wdata 0x00000012 → LW 0x8 returns 0x12ADBEEF.
  - Then SH 0x8 wdata 0xAAAA5555 → LW 0x8 returns 0x12AD5555.
- Error requests, each with err=1, done 1 cycle after accept, dm_wr never high and rdata unchanged:
  - LW 0x6.
  - SH 0x3.
  - Load with funct3=011.
- Reset pulse during LAT of SB 0x8 → dm_wr never asserted, memory word unchanged, no done; ready=1 after release and the next LW returns the old value.
- req held high with inputs changed mid-operation → only the inputs latched at acceptance are used; the second request is accepted exactly on the edge after DONE.
